// File: rtl/rev_level_tracker.sv
// Revolution level tracker: qualifies a requested level for HOLD_CYCLES samples, then ramps C one step per cycle.
// Optional overspeed flag on a sustained top level is built when REV_OVERSPEED_EN is defined.
module rev_level_tracker #(
  parameter int LEVEL_W     = 2,
  parameter int LEVELS      = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int OVS_CYCLES  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               A,
  input  logic [LEVEL_W-1:0] R,
  output logic [LEVEL_W-1:0] C,
  output logic               changed,
  output logic               busy,
  output logic               at_max
`ifdef REV_OVERSPEED_EN
  ,
  output logic               ovs
`endif
);

  localparam int CNT_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES + 1);
  localparam logic [LEVEL_W:0]   LEVELS_X = LEVELS[LEVEL_W:0];
  localparam logic [LEVEL_W-1:0] TOP_L    = LEVEL_W'(LEVELS - 1);
  localparam logic [CNT_W-1:0]   HOLD_L   = CNT_W'(HOLD_CYCLES);

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_STEADY = 2'd1,
    S_QUAL   = 2'd2,
    S_RAMP   = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [LEVEL_W-1:0] r_c, w_c_nxt;
  logic [LEVEL_W-1:0] r_cand, w_cand_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               r_changed, w_changed_nxt;
  logic [LEVEL_W-1:0] w_tgt;
  logic [LEVEL_W-1:0] w_step;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_tgt     = ({1'b0, R} < LEVELS_X) ? R : TOP_L;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_step    = (r_cand > r_c) ? (r_c + LEVEL_W'(1)) : (r_c - LEVEL_W'(1));

  always_comb begin
    w_state_nxt   = r_state;
    w_c_nxt       = r_c;
    w_cand_nxt    = r_cand;
    w_cnt_nxt     = r_cnt;
    w_changed_nxt = 1'b0;
    if (!A) begin
      w_state_nxt   = S_OFF;
      w_c_nxt       = '0;
      w_cnt_nxt     = '0;
      w_changed_nxt = (r_c != '0);
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_nxt = S_STEADY;
        end
        S_STEADY: begin
          if (w_tgt != r_c) begin
            w_cand_nxt  = w_tgt;
            w_cnt_nxt   = CNT_W'(1);
            w_state_nxt = (HOLD_CYCLES == 1) ? S_RAMP : S_QUAL;
          end else begin
            w_state_nxt = S_STEADY;
          end
        end
        S_QUAL: begin
          if (w_tgt == r_cand) begin
            w_cnt_nxt   = w_cnt_inc;
            w_state_nxt = (w_cnt_inc >= HOLD_L) ? S_RAMP : S_QUAL;
          end else if (w_tgt == r_c) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_STEADY;
          end else begin
            w_cand_nxt  = w_tgt;
            w_cnt_nxt   = CNT_W'(1);
          end
        end
        S_RAMP: begin
          // cand is latched here; R is not looked at until STEADY again
          if (r_cand != r_c) begin
            w_c_nxt       = w_step;
            w_changed_nxt = 1'b1;
            w_state_nxt   = (w_step == r_cand) ? S_STEADY : S_RAMP;
          end else begin
            w_state_nxt   = S_STEADY;
          end
          if (w_state_nxt == S_STEADY) begin
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = r_cnt;
          end
        end
        default: begin
          w_state_nxt = S_OFF;
          w_c_nxt     = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_OFF;
      r_c       <= '0;
      r_cand    <= '0;
      r_cnt     <= '0;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_c       <= w_c_nxt;
      r_cand    <= w_cand_nxt;
      r_cnt     <= w_cnt_nxt;
      r_changed <= w_changed_nxt;
    end
  end

  assign C       = r_c;
  assign changed = r_changed;
  assign busy    = (r_state == S_QUAL) || (r_state == S_RAMP);
  assign at_max  = (r_c == TOP_L);

`ifdef REV_OVERSPEED_EN
  localparam int OVS_W = (OVS_CYCLES < 2) ? 1 : $clog2(OVS_CYCLES + 1);
  localparam logic [OVS_W-1:0] OVS_L = OVS_W'(OVS_CYCLES);

  logic [OVS_W-1:0] r_ovs_cnt;
  logic             r_ovs;
  logic [OVS_W-1:0] w_ovs_inc;

  assign w_ovs_inc = (r_ovs_cnt >= OVS_L) ? r_ovs_cnt : (r_ovs_cnt + OVS_W'(1));

  // Dwell counter at the top level; ovs is sticky until engine off or reset
  always_ff @(posedge clk) begin
    if (reset || !A) begin
      r_ovs_cnt <= '0;
      r_ovs     <= 1'b0;
    end else if ((r_state == S_STEADY) && (r_c == TOP_L)) begin
      r_ovs_cnt <= w_ovs_inc;
      r_ovs     <= r_ovs | (w_ovs_inc >= OVS_L);
    end else begin
      r_ovs_cnt <= '0;
      r_ovs     <= r_ovs;
    end
  end

  assign ovs = r_ovs;
`endif

endmodule

// File: tb/tb_rev_level_tracker.sv
// Directed bench: default-parameter instance driven from a vector table, plus a
// LEVELS=3 / HOLD_CYCLES=1 instance for clamping, fast qualification and engine-off corners.
module tb_rev_level_tracker;

  logic       clk;
  logic       rst0, a0;
  logic [1:0] r0, c0;
  logic       ch0, busy0, mx0;
  logic       rst1, a1;
  logic [1:0] r1, c1;
  logic       ch1, busy1, mx1;
`ifdef REV_OVERSPEED_EN
  logic       ovs0, ovs1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rev_level_tracker dut0 (
    .clk(clk), .reset(rst0), .A(a0), .R(r0),
    .C(c0), .changed(ch0), .busy(busy0), .at_max(mx0)
`ifdef REV_OVERSPEED_EN
    , .ovs(ovs0)
`endif
  );

  rev_level_tracker #(.LEVEL_W(2), .LEVELS(3), .HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(rst1), .A(a1), .R(r1),
    .C(c1), .changed(ch1), .busy(busy1), .at_max(mx1)
`ifdef REV_OVERSPEED_EN
    , .ovs(ovs1)
`endif
  );

  typedef struct {
    logic       rst;
    logic       a;
    logic [1:0] r;
    logic [1:0] c;
    logic       ch;
    logic       busy;
    logic       mx;
  } vec_t;

  vec_t vecs[36];

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Drive dut1 for one edge, then compare its outputs just after the edge
  task automatic step1(input int idx, input logic rst, input logic a, input logic [1:0] r,
                       input int c, input int ch, input int bz, input int mx);
    @(negedge clk);
    rst1 = rst; a1 = a; r1 = r;
    @(posedge clk);
    #1;
    check("dut1.C", idx, int'(c1), c);
    check("dut1.changed", idx, int'(ch1), ch);
    check("dut1.busy", idx, int'(busy1), bz);
    check("dut1.at_max", idx, int'(mx1), mx);
  endtask

  initial begin
    //            rst   a     r      C      chg   busy  max
    vecs[0]  = '{1'b1, 1'b1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 2'd3, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 2'd3, 2'd2, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 2'd3, 2'd3, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 2'd2, 2'd3, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 2'd2, 2'd2, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 2'd1, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 2'd3, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 2'd3, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[28] = '{1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[29] = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[30] = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[31] = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0};
    vecs[32] = '{1'b0, 1'b1, 2'd2, 2'd1, 1'b1, 1'b1, 1'b0};
    vecs[33] = '{1'b1, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[34] = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0};
    vecs[35] = '{1'b0, 1'b1, 2'd2, 2'd0, 1'b0, 1'b1, 1'b0};

    rst0 = 1'b1; a0 = 1'b0; r0 = 2'd0;
    rst1 = 1'b1; a1 = 1'b0; r1 = 2'd0;

    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      rst0 = vecs[i].rst; a0 = vecs[i].a; r0 = vecs[i].r;
      @(posedge clk);
      #1;
      check("dut0.C", i, int'(c0), int'(vecs[i].c));
      check("dut0.changed", i, int'(ch0), int'(vecs[i].ch));
      check("dut0.busy", i, int'(busy0), int'(vecs[i].busy));
      check("dut0.at_max", i, int'(mx0), int'(vecs[i].mx));
    end

    // LEVELS=3, HOLD_CYCLES=1: R=3 clamps to 2, one-sample qualification
    step1(0,  1'b1, 1'b1, 2'd3, 0, 0, 0, 0);
    step1(1,  1'b0, 1'b1, 2'd3, 0, 0, 0, 0);
    step1(2,  1'b0, 1'b1, 2'd3, 0, 0, 1, 0);
    step1(3,  1'b0, 1'b1, 2'd3, 1, 1, 1, 0);
    step1(4,  1'b0, 1'b1, 2'd3, 2, 1, 0, 1);
    step1(5,  1'b0, 1'b1, 2'd3, 2, 0, 0, 1);
    // Ramp down; R moved back to 2 mid-ramp is ignored until STEADY
    step1(6,  1'b0, 1'b1, 2'd0, 2, 0, 1, 1);
    step1(7,  1'b0, 1'b1, 2'd2, 1, 1, 1, 0);
    step1(8,  1'b0, 1'b1, 2'd2, 0, 1, 0, 0);
    step1(9,  1'b0, 1'b1, 2'd2, 0, 0, 1, 0);
    step1(10, 1'b0, 1'b1, 2'd2, 1, 1, 1, 0);
    // Engine off mid-ramp at C=1
    step1(11, 1'b0, 1'b0, 2'd2, 0, 1, 0, 0);
    step1(12, 1'b0, 1'b0, 2'd2, 0, 0, 0, 0);
    step1(13, 1'b0, 1'b1, 2'd2, 0, 0, 0, 0);
    step1(14, 1'b0, 1'b1, 2'd2, 0, 0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rev_level_tracker.md
REV_LEVEL_TRACKER -- requirements
Module: rev_level_tracker

Interface
REQ-001 Parameter LEVEL_W, default 2: width of requested and reported level.
REQ-002 Parameter LEVELS, default 4: number of levels, legal range 2..2**LEVEL_W.
REQ-003 Parameter HOLD_CYCLES, default 3: consecutive matching samples needed to qualify a new request, minimum 1.
REQ-004 Parameter OVS_CYCLES, default 8: top-level dwell before overspeed flags; used only with the configuration macro.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 A  input  1  engine on (1) / off (0).
REQ-008 R  input  LEVEL_W  requested revolution level.
REQ-009 C  output  LEVEL_W  current level, registered (Moore).
REQ-010 changed  output  1  registered pulse, high in every cycle in which C holds a new value.
REQ-011 busy  output  1  high while in QUAL or RAMP.
REQ-012 at_max  output  1  high when C == LEVELS-1, decoded from the C register only.
REQ-013 ovs  output  1  overspeed flag; the port exists only when REV_OVERSPEED_EN is defined.

Function
REQ-014 Effective target tgt SHALL equal R when R < LEVELS, otherwise LEVELS-1.
REQ-015 States SHALL be OFF, STEADY, QUAL and RAMP; registers SHALL be C, cand (LEVEL_W), cnt ($clog2(HOLD_CYCLES+1) bits) and changed.
REQ-016 A=0 at any edge SHALL force next state OFF, C=0 and cnt=0, with priority over all other transitions; changed=1 if C was nonzero.
REQ-017 In OFF with A=1, the next state SHALL be STEADY and C SHALL stay 0.
REQ-018 In STEADY with tgt != C: cand<=tgt and cnt<=1; next state is QUAL, or RAMP directly when HOLD_CYCLES==1.
REQ-019 In STEADY with tgt == C, the block SHALL hold state and all registers.
REQ-020 In QUAL with tgt == cand: cnt increments; on the edge where cnt would reach HOLD_CYCLES, the next state SHALL be RAMP.
REQ-021 In QUAL with tgt == C: return to STEADY and clear cnt (glitch rejected).
REQ-022 In QUAL with tgt != cand and tgt != C: cand<=tgt and cnt<=1 (qualification restarts).
REQ-023 In RAMP, C SHALL step by exactly +1 or -1 toward cand each cycle with changed=1, and SHALL enter STEADY on the edge where C becomes cand.
REQ-024 R SHALL be ignored during RAMP because cand is latched; STEADY re-evaluates R afterward.
REQ-025 Latency: the first C change SHALL occur HOLD_CYCLES+1 edges after the first mismatching sample, then one level per cycle.
REQ-026 C SHALL never wrap and SHALL never leave the range 0..LEVELS-1.

Reset
REQ-027 reset=1 at an edge SHALL set state OFF, C=0, cand=0, cnt=0, changed=0 and ovs=0, overriding A, including mid-QUAL or mid-RAMP.
REQ-028 After reset, all outputs SHALL read 0 until the first non-reset edge.

Configuration
REQ-029 With REV_OVERSPEED_EN defined, a counter SHALL count consecutive cycles in STEADY with C==LEVELS-1, saturating at OVS_CYCLES.
REQ-030 With REV_OVERSPEED_EN defined, ovs SHALL be set on the edge the counter reaches OVS_CYCLES and stay sticky until A=0 or reset.
REQ-031 With REV_OVERSPEED_EN defined, leaving the top level SHALL clear the counter but SHALL NOT clear ovs.
REQ-032 Without REV_OVERSPEED_EN, the ovs port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (defaults unless stated)
REQ-033 reset=1 with A=1, R=3 -> C=0, changed=0, busy=0 and at_max=0; one edge after release the state is STEADY.
REQ-034 A=1, C=0, R=0->3 held -> C=0 for 3 edges, then C=1, 2, 3 on successive edges with changed=1 on each, then busy=0 and at_max=1.
REQ-035 From C=2, R=0 for one cycle then back to 2 -> C stays 2, changed never rises, busy high for 1 cycle.
REQ-036 LEVELS=3, R=3 -> C ramps to 2 and stops with at_max=1; A dropped mid-RAMP at C=1 -> C=0 next edge with changed=1.
REQ-037 HOLD_CYCLES=1, R=0->2 -> C=1 two edges after the change, C=2 the edge after that; R changes during RAMP have no effect until STEADY.
REQ-038 REV_OVERSPEED_EN, OVS_CYCLES=8: hold C=3 in STEADY -> ovs=1 after 8 cycles; R=1 -> ovs stays 1; A=0 -> ovs=0.
